// File: rtl/iob_csrs_manager.sv
// IOb manager front-end: accepts one command at a time, drives a single IOb request,
// waits for ready/rvalid with an optional timeout, and holds a completion record until taken.
module iob_csrs_manager #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    input  logic                  rsp_ready_i
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID, RSP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tmo;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // Timeout fires on the last allowed waiting cycle; an awaited event in that cycle wins.
        tmo     = (TIMEOUT != 0) && (cnt_q == TIMEOUT_W'(TIMEOUT - 1));
        cnt_inc = ((TIMEOUT != 0) && (cnt_q == TIMEOUT_W'(TIMEOUT))) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    wstrb_d = (cmd_we_i && cmd_wstrb_i == '0) ? '1 : cmd_wstrb_i;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (iob_ready_i) begin
                    if (we_q || iob_rvalid_i) begin
                        rdata_d = we_q ? '0 : iob_rdata_i;
                        err_d   = 1'b0;
                        state_d = RSP;
                    end else begin
                        state_d = WAIT_RVALID;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (tmo) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RSP;
                    end
                end
            end
            WAIT_RVALID: begin
                if (iob_rvalid_i) begin
                    rdata_d = iob_rdata_i;
                    err_d   = 1'b0;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_inc;
                    if (tmo) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RSP;
                    end
                end
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // All outputs are registers or state decodes; nothing flows through from inputs.
    assign cmd_ready_o = (state_q == IDLE);
    assign iob_valid_o = (state_q == REQ);
    assign iob_addr_o  = addr_q;
    assign iob_wdata_o = wdata_q;
    assign iob_wstrb_o = (state_q == REQ && we_q) ? wstrb_q : '0;
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_iob_csrs_manager.sv
// Self-checking bench for iob_csrs_manager: directed scenarios plus randomized transactions
// scored against a latency/outcome model derived from the timeout rules.
module tb_iob_csrs_manager;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          cke_i, rst_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic [SW-1:0] cmd_wstrb_i;
    logic          iob_valid_o;
    logic [AW-1:0] iob_addr_o;
    logic [DW-1:0] iob_wdata_o;
    logic [SW-1:0] iob_wstrb_o;
    logic          iob_ready_i, iob_rvalid_i;
    logic [DW-1:0] iob_rdata_i;
    logic          rsp_valid_o, rsp_err_o, rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iob_csrs_manager #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(8), .TIMEOUT(T)) dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_ready_i(rsp_ready_i)
    );

    typedef struct {
        int            vcyc;
        int            lat;
        logic          err;
        logic [DW-1:0] rdata;
        logic [SW-1:0] wstrb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            stable;
        bit            rsp_stable;
        bit            gap_ok;
        bit            accepted;
    } obs_t;

    // Outcome of one transaction. Subordinate asserts ready on the dr-th request cycle and,
    // for reads, rvalid dv cycles after that. Each waiting cycle without the awaited event
    // uses up one of T allowed cycles; the ready-accepted cycle itself is not counted.
    function automatic void model(input bit we, input int dr, input int dv, input logic [DW-1:0] rv,
                                  output int vcyc, output int lat, output logic err,
                                  output logic [DW-1:0] rdata);
        if (dr > T - 1) begin
            err = 1'b1; rdata = '0; vcyc = T; lat = T + 1;
        end else if (we) begin
            err = 1'b0; rdata = '0; vcyc = dr + 1; lat = dr + 2;
        end else if (dv <= T - dr) begin
            err = 1'b0; rdata = rv; vcyc = dr + 1; lat = dr + dv + 2;
        end else begin
            err = 1'b1; rdata = '0; vcyc = dr + 1; lat = T + 2;
        end
    endfunction

    function automatic logic [SW-1:0] exp_strb(input bit we, input logic [SW-1:0] ws);
        return we ? ((ws == '0) ? {SW{1'b1}} : ws) : '0;
    endfunction

    task automatic sub_drive(input int t, input bit we, input int dr, input int dv, input logic [DW-1:0] rv);
        iob_ready_i  = (t == dr + 1);
        iob_rvalid_i = !we && (t == dr + 1 + dv);
        iob_rdata_i  = iob_rvalid_i ? rv : $urandom;
    endtask

    // Runs one command from acceptance through the response handshake and records what was seen.
    task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input int dr, input int dv, input int hold,
                          input logic [DW-1:0] rv, output obs_t o);
        int t;
        o.vcyc = 0; o.lat = -1; o.err = 1'b0; o.rdata = '0; o.wstrb = '0; o.addr = '0; o.wdata = '0;
        o.stable = 1'b1; o.rsp_stable = 1'b1; o.gap_ok = 1'b0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_wstrb_i = wstrb;
        o.accepted = cmd_ready_o;
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_we_i = 1'($urandom); cmd_addr_i = AW'($urandom);
        cmd_wdata_i = $urandom; cmd_wstrb_i = SW'($urandom);
        for (t = 1; t <= 40; t++) begin
            if (rsp_valid_o) begin
                o.lat = t;
                break;
            end
            if (iob_valid_o) begin
                if (o.vcyc == 0) begin
                    o.wstrb = iob_wstrb_o; o.addr = iob_addr_o; o.wdata = iob_wdata_o;
                end else if (iob_wstrb_o !== o.wstrb || iob_addr_o !== o.addr || iob_wdata_o !== o.wdata) begin
                    o.stable = 1'b0;
                end
                o.vcyc++;
            end else if (iob_wstrb_o !== '0) begin
                o.stable = 1'b0;
            end
            sub_drive(t, we, dr, dv, rv);
            @(negedge clk);
        end
        if (o.lat < 0) begin
            iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
            return;
        end
        o.err = rsp_err_o; o.rdata = rsp_rdata_o;
        // A new command is offered throughout the response phase and must not be taken.
        for (int h = 0; h <= hold; h++) begin
            sub_drive(t + h, we, dr, dv, rv);
            cmd_valid_i = 1'b1;
            rsp_ready_i = (h == hold);
            if (!rsp_valid_o || rsp_err_o !== o.err || rsp_rdata_o !== o.rdata || cmd_ready_o)
                o.rsp_stable = 1'b0;
            @(negedge clk);
        end
        o.gap_ok = !rsp_valid_o && cmd_ready_o && !iob_valid_o;
        cmd_valid_i = 1'b0; rsp_ready_i = 1'b0; iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({iob_valid_o, iob_wstrb_o, rsp_valid_o, rsp_err_o} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", {iob_valid_o, iob_wstrb_o, rsp_valid_o, rsp_err_o});
        end
        n_chk++;
        if ({rsp_rdata_o, iob_addr_o, iob_wdata_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %0h expected 0", {rsp_rdata_o, iob_addr_o, iob_wdata_o});
        end
        rst_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready_o);
        end
    endtask

    task automatic test_write_basic();
        obs_t o;
        do_txn(1'b1, 4'h4, 32'h0000_0100, 4'h2, 1, 0, 0, '0, o);
        n_chk++;
        if (o.vcyc !== 2 || o.lat !== 3) begin
            n_fail++; $display("FAIL wr_timing: got valid=%0d lat=%0d expected valid=2 lat=3", o.vcyc, o.lat);
        end
        n_chk++;
        if (o.wstrb !== 4'h2 || o.addr !== 4'h4 || o.wdata !== 32'h100) begin
            n_fail++; $display("FAIL wr_fields: got strb=%0h addr=%0h data=%0h expected 2 4 100", o.wstrb, o.addr, o.wdata);
        end
        n_chk++;
        if (o.err !== 1'b0 || o.rdata !== '0) begin
            n_fail++; $display("FAIL wr_rsp: got err=%0b rdata=%0h expected 0 0", o.err, o.rdata);
        end
    endtask

    task automatic test_read_basic();
        obs_t o;
        do_txn(1'b0, 4'hC, 32'hDEAD_BEEF, 4'hF, 1, 1, 0, 32'h0000_0081, o);
        n_chk++;
        if (o.rdata !== 32'h81 || o.err !== 1'b0) begin
            n_fail++; $display("FAIL rd_rsp: got rdata=%0h err=%0b expected 81 0", o.rdata, o.err);
        end
        n_chk++;
        if (o.wstrb !== '0 || !o.stable || o.addr !== 4'hC) begin
            n_fail++; $display("FAIL rd_req: got strb=%0h stable=%0b addr=%0h expected 0 1 c", o.wstrb, o.stable, o.addr);
        end
        n_chk++;
        if (o.lat !== 4) begin
            n_fail++; $display("FAIL rd_latency: got %0d expected 4", o.lat);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        // Ready arrives one cycle after the abort and must be ignored in the response phase.
        do_txn(1'b1, 4'h8, 32'h1234_5678, 4'hF, 5, 0, 3, '0, o);
        n_chk++;
        if (o.vcyc !== T || o.err !== 1'b1 || o.rdata !== '0) begin
            n_fail++; $display("FAIL tmo_write: got valid=%0d err=%0b rdata=%0h expected %0d 1 0", o.vcyc, o.err, o.rdata, T);
        end
        n_chk++;
        if (!o.rsp_stable || !o.gap_ok) begin
            n_fail++; $display("FAIL tmo_late_ready: got stable=%0b gap=%0b expected 1 1", o.rsp_stable, o.gap_ok);
        end
        do_txn(1'b0, 4'h3, 32'h0, 4'h0, 1, 6, 4, 32'hCAFE_0001, o);
        n_chk++;
        if (o.err !== 1'b1 || o.rdata !== '0 || o.lat !== T + 2 || !o.rsp_stable) begin
            n_fail++; $display("FAIL tmo_wait_rvalid: got err=%0b rdata=%0h lat=%0d stable=%0b expected 1 0 %0d 1",
                               o.err, o.rdata, o.lat, o.rsp_stable, T + 2);
        end
    endtask

    task automatic test_rsp_hold();
        obs_t o;
        do_txn(1'b0, 4'h5, 32'h0, 4'h0, 0, 2, 5, 32'h5A5A_A5A5, o);
        n_chk++;
        if (!o.rsp_stable || o.rdata !== 32'h5A5A_A5A5) begin
            n_fail++; $display("FAIL rsp_hold: got stable=%0b rdata=%0h expected 1 5a5aa5a5", o.rsp_stable, o.rdata);
        end
        n_chk++;
        if (!o.gap_ok) begin
            n_fail++; $display("FAIL rsp_gap: got %0b expected 1", o.gap_ok);
        end
    endtask

    task automatic test_coincide();
        obs_t o;
        do_txn(1'b0, 4'h1, 32'h0, 4'h0, 0, 0, 0, 32'h1111_2222, o);
        n_chk++;
        if (o.rdata !== 32'h1111_2222 || o.err !== 1'b0 || o.lat !== 2) begin
            n_fail++; $display("FAIL co_ready_rvalid: got rdata=%0h err=%0b lat=%0d expected 11112222 0 2", o.rdata, o.err, o.lat);
        end
        do_txn(1'b0, 4'h2, 32'h0, 4'h0, 0, T, 0, 32'h3333_4444, o);
        n_chk++;
        if (o.rdata !== 32'h3333_4444 || o.err !== 1'b0) begin
            n_fail++; $display("FAIL co_rvalid_tmo: got rdata=%0h err=%0b expected 33334444 0", o.rdata, o.err);
        end
        do_txn(1'b1, 4'h6, 32'h77, 4'h1, T - 1, 0, 0, '0, o);
        n_chk++;
        if (o.err !== 1'b0 || o.vcyc !== T) begin
            n_fail++; $display("FAIL co_ready_tmo: got err=%0b valid=%0d expected 0 %0d", o.err, o.vcyc, T);
        end
    endtask

    task automatic test_zero_wstrb();
        obs_t o;
        do_txn(1'b1, 4'hA, 32'hFFFF_0000, 4'h0, 0, 0, 0, '0, o);
        n_chk++;
        if (o.wstrb !== 4'hF) begin
            n_fail++; $display("FAIL zero_wstrb: got %0h expected f", o.wstrb);
        end
    endtask

    task automatic test_cke();
        int vc, lat;
        vc = 0; lat = -1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 4'h7; cmd_wdata_i = 32'h9; cmd_wstrb_i = 4'h3;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        // Three frozen cycles with ready asserted: neither the ready nor the counter may move.
        for (int t = 1; t <= 30; t++) begin
            if (rsp_valid_o) begin
                lat = t;
                break;
            end
            if (iob_valid_o) vc++;
            cke_i = (t > 3);
            iob_ready_i = (t <= 3);
            @(negedge clk);
        end
        cke_i = 1'b1; iob_ready_i = 1'b0;
        n_chk++;
        if (vc !== T + 3 || lat !== T + 4 || rsp_err_o !== 1'b1) begin
            n_fail++; $display("FAIL cke_hold: got valid=%0d lat=%0d err=%0b expected %0d %0d 1", vc, lat, rsp_err_o, T + 3, T + 4);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        bit seen;
        seen = 1'b0;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 4'hE; cmd_wdata_i = 32'hABCD; cmd_wstrb_i = 4'h0;
        @(negedge clk);
        cmd_valid_i = 1'b0; iob_ready_i = 1'b1;
        @(negedge clk);
        iob_ready_i = 1'b0;
        n_chk++;
        if (iob_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstw_in_wait: got valid=%0b rsp=%0b expected 0 0", iob_valid_o, rsp_valid_o);
        end
        rst_i = 1'b1; cke_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0; cke_i = 1'b1;
        n_chk++;
        if ({iob_valid_o, iob_wstrb_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, iob_addr_o, iob_wdata_o} !== '0
            || cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rstw_outputs: got valid=%0b rsp=%0b addr=%0h cmd_ready=%0b expected 0 0 0 1",
                               iob_valid_o, rsp_valid_o, iob_addr_o, cmd_ready_o);
        end
        iob_rvalid_i = 1'b1; iob_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        iob_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid_o || rsp_rdata_o !== '0) seen = 1'b1;
            @(negedge clk);
        end
        n_chk++;
        if (seen) begin
            n_fail++; $display("FAIL rstw_late_rvalid: got response=1 expected 0");
        end
    endtask

    task automatic test_random();
        obs_t          o;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rv, er;
        logic [SW-1:0] s;
        int            dr, dv, ev, el;
        logic          ee;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); a = AW'($urandom); d = $urandom; rv = $urandom;
            s  = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
            dr = $urandom_range(0, 5); dv = $urandom_range(0, 6);
            do_txn(we, a, d, s, dr, dv, $urandom_range(0, 3), rv, o);
            model(we, dr, dv, rv, ev, el, ee, er);
            n_chk++;
            if (o.lat !== el || o.vcyc !== ev) begin
                n_fail++; $display("FAIL rnd%0d timing: got lat=%0d valid=%0d expected %0d %0d", i, o.lat, o.vcyc, el, ev);
            end
            n_chk++;
            if (o.err !== ee || o.rdata !== er) begin
                n_fail++; $display("FAIL rnd%0d rsp: got err=%0b rdata=%0h expected %0b %0h", i, o.err, o.rdata, ee, er);
            end
            n_chk++;
            if (o.wstrb !== exp_strb(we, s) || o.addr !== a || o.wdata !== d || !o.stable) begin
                n_fail++; $display("FAIL rnd%0d req: got strb=%0h addr=%0h data=%0h stable=%0b expected %0h %0h %0h 1",
                                   i, o.wstrb, o.addr, o.wdata, o.stable, exp_strb(we, s), a, d);
            end
            n_chk++;
            if (!o.accepted || !o.rsp_stable || !o.gap_ok) begin
                n_fail++; $display("FAIL rnd%0d handshake: got acc=%0b stable=%0b gap=%0b expected 1 1 1",
                                   i, o.accepted, o.rsp_stable, o.gap_ok);
            end
        end
    endtask

    initial begin
        cke_i = 1'b1; rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_wstrb_i = '0;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0; rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_rsp_hold();
        test_coincide();
        test_zero_wstrb();
        test_cke();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/iob_csrs_manager.md
IOB_CSRS_MANAGER -- requirements
Module: iob_csrs_manager

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the IOb byte-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width, a multiple of 8.
REQ-003 Parameter TIMEOUT_W, default 8, SHALL set the timeout counter width.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the wait cycles before abort; 0 SHALL disable timeout.
REQ-005 Port clk_i, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port cke_i, input, 1: clock enable; when 0, all registers except reset SHALL hold.
REQ-007 Port rst_i, input, 1: reset is synchronous and active-high.
REQ-008 Port cmd_valid_i, input, 1: a command is offered.
REQ-009 Port cmd_ready_o, output, 1: the block accepts the command.
REQ-010 Port cmd_we_i, input, 1: 1 means write, 0 means read.
REQ-011 Port cmd_addr_i, input, ADDR_W: the byte address.
REQ-012 Ports cmd_wdata_i (DATA_W) and cmd_wstrb_i (DATA_W/8), inputs: the write data and byte strobes.
REQ-013 Ports iob_valid_o (1), iob_addr_o (ADDR_W), iob_wdata_o (DATA_W) and iob_wstrb_o (DATA_W/8), outputs: the IOb manager request.
REQ-014 Ports iob_ready_i (1), iob_rvalid_i (1) and iob_rdata_i (DATA_W), inputs: the IOb subordinate response.
REQ-015 Ports rsp_valid_o (1), rsp_rdata_o (DATA_W) and rsp_err_o (1), outputs: the completion record, with rsp_ready_i (1) as input.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, WAIT_RVALID and RSP.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE.
REQ-018 In IDLE, cmd_valid_i&cmd_ready_o SHALL latch we, addr, wdata and wstrb, clear the counter, and enter REQ.
REQ-019 In REQ, iob_valid_o SHALL be 1 with latched addr and wdata; iob_wstrb_o SHALL be latched wstrb for writes and 0 for reads.
REQ-020 Outside REQ, iob_valid_o SHALL be 0 and iob_wstrb_o SHALL be 0.
REQ-021 Request fields SHALL stay constant from REQ entry until REQ exit.
REQ-022 A write with cmd_wstrb_i=0 SHALL be forced to wstrb all-ones.
REQ-023 A write in REQ with iob_ready_i=1 SHALL go to RSP with rsp_err_o=0 and rsp_rdata_o=0.
REQ-024 A read in REQ with iob_ready_i=1 and iob_rvalid_i=0 SHALL go to WAIT_RVALID.
REQ-025 A read in REQ with iob_ready_i=1 and iob_rvalid_i=1 SHALL capture iob_rdata_i and go directly to RSP.
REQ-026 In WAIT_RVALID, iob_rvalid_i=1 SHALL capture iob_rdata_i into rsp_rdata_o and go to RSP with err=0.
REQ-027 In REQ and WAIT_RVALID, the counter SHALL increment each enabled cycle without the awaited event.
REQ-028 If TIMEOUT≠0, the counter SHALL saturate at TIMEOUT.
REQ-029 If TIMEOUT≠0 and count==TIMEOUT-1 with no awaited event, the FSM SHALL go to RSP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-030 If the awaited event and timeout coincide, the event SHALL win and err SHALL be 0.
REQ-031 In RSP, rsp_valid_o SHALL be 1 and the response fields SHALL be stable until rsp_ready_i=1, then the FSM SHALL return to IDLE.
REQ-032 iob_rvalid_i or iob_ready_i asserted in IDLE or RSP SHALL be ignored, with no state or data change.
REQ-033 No new command SHALL be accepted in the cycle rsp_valid_o&rsp_ready_i occurs; the minimum gap is one IDLE cycle.
REQ-034 Against a subordinate with a registered ready, a write SHALL complete in 3 cycles from acceptance to rsp_valid_o, and a read in 4.
REQ-035 Every output SHALL be a direct register or state decode, with no combinational path from any input.

Reset
REQ-036 rst_i=1 at a clock edge SHALL force IDLE regardless of cke_i.
REQ-037 After reset, iob_valid_o, iob_wstrb_o, rsp_valid_o, rsp_err_o and the counter SHALL be 0, and rsp_rdata_o, iob_addr_o and iob_wdata_o SHALL be 0.
REQ-038 Reset during REQ or WAIT_RVALID SHALL drop iob_valid_o the next cycle, and a subsequent late rvalid SHALL be ignored.

Verification
REQ-039 Write addr=0x4, wdata=0x0000_0100, wstrb=0x2 to a ready-after-1 subordinate -> iob_valid_o high 2 cycles, iob_wstrb_o=0x2, rsp_valid_o 3 cycles after acceptance, err=0.
REQ-040 Read addr=0xC from a subordinate returning 0x0000_0081 one cycle after ready -> rsp_rdata_o=0x81, err=0, iob_wstrb_o=0 throughout.
REQ-041 TIMEOUT=4 with iob_ready_i held 0 -> iob_valid_o high 4 cycles, then rsp_err_o=1, rsp_rdata_o=0; a later ready/rvalid is ignored.
REQ-042 Hold rsp_ready_i=0 for 5 cycles in RSP -> rsp fields stable, cmd_ready_o=0, and a new cmd_valid_i is not accepted.
REQ-043 Assert rst_i in WAIT_RVALID, then pulse iob_rvalid_i -> IDLE, all outputs 0, and no response emitted.
REQ-044 Drive iob_ready_i and iob_rvalid_i together on a read, and rvalid coinciding with the timeout cycle -> rdata captured and err=0 in both cases.
